dmem_copy_master: RTL

- Bus initiator for the 16-bit data memory: drives memRead/memWrite/addr/wdata and consumes rdata.
- On a start command it copies a block of `length` words from `src_base` to `dst_base` in ascending address order.
- It accumulates a wrapping 16-bit checksum of the copied words.
- It sits beside the datapath as a memory-to-memory mover, arbitrated so it owns the memory port while busy.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_copy_master.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for data-memory initiators: copy FSM states, default
// port geometry, and the block range check.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_DEPTH  = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        READ   = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } copy_state_e;

    // True when the whole block [base, base+len-1] lies below depth. The extra
    // top bit keeps a wrap past the end of the address space visible as out of
    // range. Callers handle len==0 themselves.
    function automatic logic range_ok(input logic [DMEM_ADDR_W-1:0] base,
                                      input logic [DMEM_ADDR_W-1:0] len,
                                      input logic [DMEM_ADDR_W:0]   depth);
        logic [DMEM_ADDR_W:0] last;
        last = {1'b0, base} + {1'b0, len} - {{DMEM_ADDR_W{1'b0}}, 1'b1};
        return last < depth;
    endfunction

endpackage

// File: rtl/dmem_copy_master.sv
// Memory-to-memory block copier on the 16-bit data memory port, with a
// wrapping checksum of every word moved.
//
// Command handshake: start is sampled only while in IDLE (ignored otherwise,
// never queued); the command retires with a single-cycle done pulse, whether
// it copied, was empty, or failed the range check. busy covers CHECK/READ/WRITE.
module dmem_copy_master
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int MEM_DEPTH = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    copy_state_e       state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        idx_d    = idx_q;
        data_d   = data_q;
        csum_d   = csum_q;
        err_d    = err_q;
        busy     = 1'b0;
        done     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        addr     = '0;
        wdata    = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    len_d   = length;
                    idx_d   = '0;
                    csum_d  = '0;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                busy = 1'b1;
                if (len_q == '0) begin
                    state_d = FINISH;
                end else if (!range_ok(src_q, len_q, DEPTH_LIM) ||
                             !range_ok(dst_q, len_q, DEPTH_LIM)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = READ;
                end
            end

            READ: begin
                busy    = 1'b1;
                memRead = 1'b1;
                addr    = src_q + idx_q;
                data_d  = rdata;
                csum_d  = csum_q + rdata;
                state_d = WRITE;
            end

            // Each word is written right after its own read, so an overlapping
            // forward copy (dst = src+1) replicates the first word by design.
            WRITE: begin
                busy     = 1'b1;
                memWrite = 1'b1;
                addr     = dst_q + idx_q;
                wdata    = data_q;
                if (idx_q == len_q - ADDR_W'(1)) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = READ;
                end
            end

            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign err      = err_q;
    assign checksum = csum_q;

endmodule
